// File: rtl/vector_load_pkg.sv
// rtl/vector_load_pkg.sv - shared types and helpers for the vector memory loader
// Purpose: FSM state encoding, lane count, lane index type and the position
// width helper used by vector_load_ctrl and lane_packer.
package vector_load_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIX_FILL = 3'd1,
    PIX_WR   = 3'd2,
    MUL_FILL = 3'd3,
    MUL_WR   = 3'd4,
    DONE     = 3'd5
  } vload_state_t;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  // Width of a vector position field; a single-entry memory still gets one bit.
  function automatic int pos_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_packer.sv
// rtl/lane_packer.sv - 4-lane word packer shared by the pixel and multiplier sections
// Purpose: captures successive stream words into lanes 0..3 and flags the
// handshake that completes a vector.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous reset, active-low
//   clr_i    restart the word count at lane 0 (lanes keep their contents)
//   push_i   a word is accepted this cycle
//   data_i   accepted word
//   lanes_o  packed lanes, lane 0 = first word of the vector
//   full_o   this push fills the last lane
module lane_packer
  import vector_load_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [DW-1:0]             data_i,
  output logic [LANES-1:0][DW-1:0]  lanes_o,
  output logic                      full_o
);

  lane_idx_t                  cnt_q, cnt_d;
  logic [LANES-1:0][DW-1:0]   lanes_q, lanes_d;

  always_comb begin
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      lanes_d[cnt_q] = data_i;
      cnt_d          = cnt_q + 2'd1;  // wraps to lane 0 after the last lane
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  assign lanes_o = lanes_q;
  assign full_o  = push_i && (cnt_q == lane_idx_t'(LANES - 1));

endmodule

// File: rtl/vector_load_ctrl.sv
// rtl/vector_load_ctrl.sv - packs a word stream into pixel and multiplier vector writes
// Purpose: after start, loads PIX_VECS pixel vectors then MUL_VECS multiplier
// vectors (4 words each) and pulses done_o. Optional macro VLOAD_CHECKSUM_EN
// enables a running XOR of the accepted frame words on checksum_o.
// Ports:
//   clk_i, rst_ni                  clock / asynchronous active-low reset
//   start_i, abort_i               frame start (IDLE only) / synchronous cancel
//   in_valid_i, in_ready_o, in_data_i   word stream
//   we_pxl_o, wr_pos_pxl_o, wdp1_o..wdp4_o        pixel memory write port
//   we_mul_o, wr_mul_pos_in_o, wdm1_o..wdm4_o     multiplier memory write port
//   busy_o, done_o, checksum_o     status
module vector_load_ctrl
  import vector_load_pkg::*;
#(
  parameter  int DW       = 32,
  parameter  int PIX_VECS = 2,
  parameter  int MUL_VECS = 2,
  localparam int PW       = pos_width(PIX_VECS),
  localparam int MW       = pos_width(MUL_VECS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          we_pxl_o,
  output logic [PW-1:0] wr_pos_pxl_o,
  output logic [DW-1:0] wdp1_o,
  output logic [DW-1:0] wdp2_o,
  output logic [DW-1:0] wdp3_o,
  output logic [DW-1:0] wdp4_o,
  output logic          we_mul_o,
  output logic [MW-1:0] wr_mul_pos_in_o,
  output logic [DW-1:0] wdm1_o,
  output logic [DW-1:0] wdm2_o,
  output logic [DW-1:0] wdm3_o,
  output logic [DW-1:0] wdm4_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] checksum_o
);

  localparam int              VW       = (PW > MW) ? PW : MW;
  localparam logic [VW-1:0]   PIX_LAST = VW'(PIX_VECS - 1);
  localparam logic [VW-1:0]   MUL_LAST = VW'(MUL_VECS - 1);

  vload_state_t               state_q, state_d;
  logic [VW-1:0]              vec_q, vec_d;
  logic [LANES-1:0][DW-1:0]   lanes;
  logic [LANES-1:0][DW-1:0]   pix_hold_q, mul_hold_q;
  logic [LANES-1:0][DW-1:0]   pix_vec, mul_vec;
  logic [PW-1:0]              pix_pos_q;
  logic [MW-1:0]              mul_pos_q;
  logic                       push, full, start_acc;

  // abort drops the word offered in the same cycle, including a 4th word.
  assign push      = in_valid_i && in_ready_o && !abort_i;
  assign start_acc = (state_q == IDLE) && start_i && !abort_i;

  lane_packer #(.DW(DW)) u_packer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (abort_i || start_acc),
    .push_i  (push),
    .data_i  (in_data_i),
    .lanes_o (lanes),
    .full_o  (full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    if (abort_i) begin
      state_d = IDLE;
      vec_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          state_d = PIX_FILL;
          vec_d   = '0;
        end
        PIX_FILL: if (full) state_d = PIX_WR;
        PIX_WR: begin
          if (vec_q == PIX_LAST) begin
            state_d = MUL_FILL;
            vec_d   = '0;
          end else begin
            state_d = PIX_FILL;
            vec_d   = vec_q + 1'b1;
          end
        end
        MUL_FILL: if (full) state_d = MUL_WR;
        MUL_WR: begin
          if (vec_q == MUL_LAST) begin
            state_d = DONE;
            vec_d   = '0;
          end else begin
            state_d = MUL_FILL;
            vec_d   = vec_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o = 1'b0;
    we_pxl_o   = 1'b0;
    we_mul_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      PIX_FILL: begin in_ready_o = 1'b1; busy_o = 1'b1; end
      PIX_WR:   begin we_pxl_o   = 1'b1; busy_o = 1'b1; end
      MUL_FILL: begin in_ready_o = 1'b1; busy_o = 1'b1; end
      MUL_WR:   begin we_mul_o   = 1'b1; busy_o = 1'b1; end
      DONE:     done_o = 1'b1;
      default:  ;
    endcase
  end

  // The packer is reused by the next fill, so each port latches its vector
  // on its strobe and shows the live packer lanes only during the strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_hold_q <= '0;
      mul_hold_q <= '0;
      pix_pos_q  <= '0;
      mul_pos_q  <= '0;
    end else begin
      if (we_pxl_o) begin
        pix_hold_q <= lanes;
        pix_pos_q  <= vec_q[PW-1:0];
      end
      if (we_mul_o) begin
        mul_hold_q <= lanes;
        mul_pos_q  <= vec_q[MW-1:0];
      end
    end
  end

  assign pix_vec         = we_pxl_o ? lanes : pix_hold_q;
  assign mul_vec         = we_mul_o ? lanes : mul_hold_q;
  assign wr_pos_pxl_o    = we_pxl_o ? vec_q[PW-1:0] : pix_pos_q;
  assign wr_mul_pos_in_o = we_mul_o ? vec_q[MW-1:0] : mul_pos_q;
  assign wdp1_o = pix_vec[0];
  assign wdp2_o = pix_vec[1];
  assign wdp3_o = pix_vec[2];
  assign wdp4_o = pix_vec[3];
  assign wdm1_o = mul_vec[0];
  assign wdm2_o = mul_vec[1];
  assign wdm3_o = mul_vec[2];
  assign wdm4_o = mul_vec[3];

`ifdef VLOAD_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc)  csum_d = '0;
    else if (push)  csum_d = csum_q ^ in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_vector_load_ctrl.sv
// tb/tb_vector_load_ctrl.sv - self-checking bench for vector_load_ctrl
module tb_vector_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid, in_ready;
  logic [31:0] in_data;
  logic        we_pxl, we_mul, busy, done;
  logic [0:0]  wr_pos_pxl, wr_mul_pos;
  logic [31:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4, checksum;

  always #5 clk = ~clk;

  vector_load_ctrl #(.DW(32), .PIX_VECS(2), .MUL_VECS(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .we_pxl_o(we_pxl), .wr_pos_pxl_o(wr_pos_pxl),
    .wdp1_o(wdp1), .wdp2_o(wdp2), .wdp3_o(wdp3), .wdp4_o(wdp4),
    .we_mul_o(we_mul), .wr_mul_pos_in_o(wr_mul_pos),
    .wdm1_o(wdm1), .wdm2_o(wdm2), .wdm3_o(wdm3), .wdm4_o(wdm4),
    .busy_o(busy), .done_o(done), .checksum_o(checksum)
  );

  typedef struct packed {
    logic            mul;
    logic [0:0]      pos;
    logic [127:0]    lanes;
  } exp_wr_t;

  typedef struct {
    logic [15:0][31:0] w;
    int                stall_at;
    int                stall_len;
    bit                spam;
    int                exp_first;
    int                exp_done;
  } row_t;

  exp_wr_t sbq[$];
  row_t    rows[3];
  int      tests = 0, fails = 0;
  int      cyc = 0, strobes = 0, dones = 0, first_wr = -1, done_cyc = 0;
  logic [31:0] last_wdp1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expected write.
  always @(negedge clk) begin
    exp_wr_t e;
    if (rst_n) begin
      if (we_pxl && we_mul) check("strobe_exclusive", 1, 0);
      if (we_pxl || we_mul) begin
        strobes++;
        if (first_wr < 0) first_wr = cyc;
        if (sbq.size() == 0) begin
          check("unexpected_strobe", {we_pxl, we_mul}, 0);
        end else begin
          e = sbq.pop_front();
          check("wr_section", we_mul, e.mul);
          check("wr_pos", we_mul ? wr_mul_pos : wr_pos_pxl, e.pos);
          check("wr_lanes", we_mul ? {wdm4, wdm3, wdm2, wdm1} : {wdp4, wdp3, wdp2, wdp1}, e.lanes);
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, output bit ok);
    bit acc;
    in_data  = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("word_accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input row_t r);
    int s0, d0, t0;
    bit ok, seen;
    logic [31:0] cs;
    exp_wr_t e;
    first_wr = -1;
    s0 = strobes;
    d0 = dones;
    cs = '0;
    start = 1'b1;
    t0 = cyc;
    step();
    start = r.spam;
    check("busy_after_start", busy, 1);
    check("ready_after_start", in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == r.stall_at) begin
        in_valid = 1'b0;
        repeat (r.stall_len) step();
      end
      if (i == 14) start = 1'b0;
      send_word(r.w[i], ok);
      if (!ok) return;
      cs ^= r.w[i];
      if (i % 4 == 3) begin
        e.mul   = (i >= 8);
        e.pos   = 1'((i % 8) / 4);
        e.lanes = {r.w[i], r.w[i-1], r.w[i-2], r.w[i-3]};
        sbq.push_back(e);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dones != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("first_strobe_latency", first_wr - t0, r.exp_first);
    check("done_latency", done_cyc - t0, r.exp_done);
`ifdef VLOAD_CHECKSUM_EN
    check("checksum", checksum, cs);
`else
    check("checksum", checksum, 0);
`endif
    step();
    check("idle_after_done", {busy, done, in_ready}, 0);
    check("strobes_per_frame", strobes - s0, 4);
    check("dones_per_frame", dones - d0, 1);
    check("scoreboard_drained", sbq.size(), 0);
    last_wdp1 = r.w[4];
  endtask

  logic [31:0] nom [16] = '{
    32'h416D5267, 32'h416D5263, 32'h415D5267, 32'h426D5267,
    32'h416D5367, 32'h416C5263, 32'h415D5267, 32'h426D506B,
    32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888,
    32'h9999AAAA, 32'hBBBBCCCC, 32'hDDDDEEEE, 32'hFFFF0000};

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 16; i++) begin
      rows[0].w[i] = nom[i];
      rows[1].w[i] = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      rows[2].w[i] = 32'(i + 1);
    end
    rows[0].stall_at = -1; rows[0].stall_len = 0; rows[0].spam = 1'b0;
    rows[0].exp_first = 5; rows[0].exp_done = 21;
    rows[1].stall_at = 2;  rows[1].stall_len = 3; rows[1].spam = 1'b0;
    rows[1].exp_first = 8; rows[1].exp_done = 24;
    rows[2].stall_at = -1; rows[2].stall_len = 0; rows[2].spam = 1'b1;
    rows[2].exp_first = 5; rows[2].exp_done = 21;

    repeat (3) step();
    check("reset_ctrl", {in_ready, we_pxl, we_mul, busy, done, wr_pos_pxl, wr_mul_pos}, 0);
    check("reset_pix_lanes", {wdp4, wdp3, wdp2, wdp1}, 0);
    check("reset_mul_lanes", {wdm4, wdm3, wdm2, wdm1}, 0);
    check("reset_checksum", checksum, 0);
    rst_n = 1'b1;
    step();
    check("idle_not_ready", in_ready, 0);

    for (int r = 0; r < 2; r++) run_frame(rows[r]);

    // abort coinciding with the 4th pixel word
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(32'hDEAD0000 + 32'(i), ok);
    in_data = 32'hDEAD0003;
    in_valid = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_idle", {in_ready, busy, we_pxl, done}, 0);
    check("abort_keeps_pos", wr_pos_pxl, 1);
    check("abort_keeps_lane", wdp1, last_wdp1);
    repeat (3) step();
    check("abort_no_strobe", sbq.size(), 0);

    run_frame(rows[0]);
    run_frame(rows[2]);

    // reset mid pixel fill after two words
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(32'h01234567, ok);
    send_word(32'h89ABCDEF, ok);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {in_ready, we_pxl, we_mul, busy, done, wr_pos_pxl, wr_mul_pos}, 0);
    check("midreset_pix_lanes", {wdp4, wdp3, wdp2, wdp1}, 0);
    check("midreset_mul_lanes", {wdm4, wdm3, wdm2, wdm1}, 0);
    check("midreset_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_not_ready", {in_ready, busy}, 0);
    end
    step();
    run_frame(rows[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
